// File: rtl/smpl_cnt_mon.sv
// Per-triangle hit-count monitor: counts lane hits per triangle and checks them against a FIFO
// of golden counts. Defining SMPL_CNT_MON_MAX_EN adds max_cnt and zero_tri_cnt statistics.
module smpl_cnt_mon #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ECNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  input  logic [CNT_W-1:0]       exp_count,
  input  logic [LANES-1:0]       hit_valid,
  input  logic                   hit_eot,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic [CNT_W-1:0]       err_got,
  output logic [CNT_W-1:0]       err_exp,
  output logic                   err_sticky,
  output logic [ECNT_W-1:0]      err_cnt,
  output logic [ECNT_W-1:0]      tri_cnt,
`ifdef SMPL_CNT_MON_MAX_EN
  output logic [CNT_W-1:0]       max_cnt,
  output logic [ECNT_W-1:0]      zero_tri_cnt,
`endif
  output logic [$clog2(DEPTH):0] fifo_lvl
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(LANES + 1);
  localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

  function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
    return (v == '1) ? v : v + ECNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  mem_q [DEPTH];
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CNT_W-1:0]  err_got_q, err_got_d, err_exp_q, err_exp_d;
  logic              err_sticky_q, err_sticky_d;
  logic [ECNT_W-1:0] err_cnt_q, err_cnt_d, tri_cnt_q, tri_cnt_d;

  logic [PW-1:0]     pop_cnt;
  logic [SW-1:0]     sum_wide;
  logic [CNT_W-1:0]  sum, head;
  logic              fifo_empty, fifo_full, push, pop;

  always_comb begin
    pop_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pop_cnt = pop_cnt + PW'(hit_valid[i]);
    end
  end

  assign sum_wide = SW'(acc_q) + SW'(pop_cnt);
  assign sum      = (|sum_wide[SW-1:CNT_W]) ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign exp_ready  = ~fifo_full;
  assign fifo_lvl   = wr_ptr_q - rd_ptr_q;
  assign push       = exp_valid && !fifo_full && !clear;
  assign pop        = hit_eot && !fifo_empty && !clear;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= exp_count;
  end

  always_comb begin
    acc_d        = acc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;
    err_got_d    = err_got_q;
    err_exp_d    = err_exp_q;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    tri_cnt_d    = tri_cnt_q;
    if (clear) begin
      acc_d        = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
      tri_cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
      if (hit_eot) begin
        acc_d     = '0;
        tri_cnt_d = sat_inc(tri_cnt_q);
        // A same-cycle push never bypasses into the check.
        if (fifo_empty) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'b10;
          err_got_d   = sum;
          err_exp_d   = '0;
        end else if (head != sum) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'b01;
          err_got_d   = sum;
          err_exp_d   = head;
        end
        if (err_valid_d) begin
          err_sticky_d = 1'b1;
          err_cnt_d    = sat_inc(err_cnt_q);
        end
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_got_q    <= '0;
      err_exp_q    <= '0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      tri_cnt_q    <= '0;
    end else begin
      acc_q        <= acc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_got_q    <= err_got_d;
      err_exp_q    <= err_exp_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      tri_cnt_q    <= tri_cnt_d;
    end
  end

  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_got    = err_got_q;
  assign err_exp    = err_exp_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign tri_cnt    = tri_cnt_q;

`ifdef SMPL_CNT_MON_MAX_EN
  logic [CNT_W-1:0]  max_cnt_q, max_cnt_d;
  logic [ECNT_W-1:0] zero_tri_q, zero_tri_d;

  always_comb begin
    max_cnt_d  = max_cnt_q;
    zero_tri_d = zero_tri_q;
    if (clear) begin
      max_cnt_d  = '0;
      zero_tri_d = '0;
    end else if (hit_eot) begin
      if (sum > max_cnt_q) max_cnt_d = sum;
      if (sum == '0) zero_tri_d = sat_inc(zero_tri_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_cnt_q  <= '0;
      zero_tri_q <= '0;
    end else begin
      max_cnt_q  <= max_cnt_d;
      zero_tri_q <= zero_tri_d;
    end
  end

  assign max_cnt      = max_cnt_q;
  assign zero_tri_cnt = zero_tri_q;
`endif

endmodule

// File: tb/tb_smpl_cnt_mon.sv
// Bench for smpl_cnt_mon: directed vector table, reset sequence, and randomized traffic
// against a queue-based reference model (max statistics checked when SMPL_CNT_MON_MAX_EN is set).
module tb_smpl_cnt_mon;

  localparam int DEPTH = 8;
  localparam int CMAX  = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_ready;
  logic [15:0] exp_count = '0;
  logic [3:0]  hit_valid = '0;
  logic        hit_eot = 1'b0;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] err_got, err_exp;
  logic        err_sticky;
  logic [15:0] err_cnt, tri_cnt;
  logic [3:0]  fifo_lvl;
`ifdef SMPL_CNT_MON_MAX_EN
  logic [15:0] max_cnt, zero_tri_cnt;
`endif

  smpl_cnt_mon #(.LANES(4), .CNT_W(16), .DEPTH(DEPTH), .ECNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_count(exp_count),
    .hit_valid(hit_valid), .hit_eot(hit_eot),
    .err_valid(err_valid), .err_code(err_code), .err_got(err_got), .err_exp(err_exp),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .tri_cnt(tri_cnt),
`ifdef SMPL_CNT_MON_MAX_EN
    .max_cnt(max_cnt), .zero_tri_cnt(zero_tri_cnt),
`endif
    .fifo_lvl(fifo_lvl)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic clr; logic ev; int ec; logic [3:0] hv; logic eot;
    logic rdy; int lvl; int tri_n; logic errv; int code; int got; int expv; logic st; int ecnt;
  } vec_t;
  vec_t tbl[$];

  // reference model state
  int mq[$];
  int m_acc, m_tri, m_ecnt, m_code, m_got, m_exp, m_max, m_zero;
  bit m_st, m_ev;

  function automatic vec_t mk(input logic clr, ev, input int ec, input logic [3:0] hv,
                              input logic eot, input logic rdy, input int lvl, tri_n,
                              input logic errv, input int code, got, expv,
                              input logic st, input int ecnt);
    vec_t v;
    v.clr = clr; v.ev = ev; v.ec = ec; v.hv = hv; v.eot = eot;
    v.rdy = rdy; v.lvl = lvl; v.tri_n = tri_n; v.errv = errv; v.code = code;
    v.got = got; v.expv = expv; v.st = st; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input int lvl, tri_n,
                         input logic errv, input int code, got, expv,
                         input logic st, input int ecnt);
    chk({tag, " exp_ready"}, int'(exp_ready), int'(rdy));
    chk({tag, " fifo_lvl"}, int'(fifo_lvl), lvl);
    chk({tag, " tri_cnt"}, int'(tri_cnt), tri_n);
    chk({tag, " err_valid"}, int'(err_valid), int'(errv));
    chk({tag, " err_code"}, int'(err_code), code);
    chk({tag, " err_got"}, int'(err_got), got);
    chk({tag, " err_exp"}, int'(err_exp), expv);
    chk({tag, " err_sticky"}, int'(err_sticky), int'(st));
    chk({tag, " err_cnt"}, int'(err_cnt), ecnt);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic drive(input logic c, ev, input int ec, input logic [3:0] hv, input logic eot);
    clear = c; exp_valid = ev; exp_count = 16'(ec); hit_valid = hv; hit_eot = eot;
    @(posedge clk); #1;
    clear = 1'b0; exp_valid = 1'b0; hit_valid = '0; hit_eot = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_acc = 0; m_tri = 0; m_ecnt = 0; m_code = 0; m_got = 0; m_exp = 0;
    m_max = 0; m_zero = 0; m_st = 0; m_ev = 0;
  endtask

  task automatic model_step(input logic c, ev, input int ec, input logic [3:0] hv,
                            input logic eot);
    int  s, h;
    bit  full, empty;
    m_ev = 0;
    if (c) begin
      mq.delete();
      m_acc = 0; m_tri = 0; m_ecnt = 0; m_st = 0; m_max = 0; m_zero = 0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      s = m_acc + $countones(hv);
      if (s > CMAX) s = CMAX;
      if (eot) begin
        if (m_tri < CMAX) m_tri++;
        if (empty) begin
          m_ev = 1; m_code = 2; m_got = s; m_exp = 0;
        end else begin
          h = mq.pop_front();
          if (h != s) begin
            m_ev = 1; m_code = 1; m_got = s; m_exp = h;
          end
        end
        if (m_ev) begin
          m_st = 1;
          if (m_ecnt < CMAX) m_ecnt++;
        end
        if (s > m_max) m_max = s;
        if (s == 0 && m_zero < CMAX) m_zero++;
        m_acc = 0;
      end else begin
        m_acc = s;
      end
      if (ev && !full) mq.push_back(ec);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic c, ev, eot;
    logic [3:0] hv;
    int ec;

    // clr ev ec hv eot | rdy lvl tri errv code got exp st ecnt
    tbl.push_back(mk(0, 1, 5, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0001, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 4'b0000, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0011, 1, 1, 0, 2, 1, 1, 2, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 0, 2, 0, 1, 2, 3, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'b0001, 1, 1, 1, 3, 1, 2, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 1, 3, 0, 2, 1, 0, 1, 2));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, 1, 10 + i, 4'b0000, 0, (i < 6), 2 + i, 3, 0, 2, 1, 0, 1, 2));
    tbl.push_back(mk(0, 1, 99, 4'b0001, 1, 1, 7, 4, 0, 2, 1, 0, 1, 2));
    tbl.push_back(mk(1, 1, 42, 4'b1111, 1, 1, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 1, 0, 1, 1, 2, 0, 0, 1, 1));

    do_reset();
    chk_all("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.clr, v.ev, v.ec, v.hv, v.eot);
      chk_all($sformatf("row%0d", i), v.rdy, v.lvl, v.tri_n, v.errv, v.code, v.got, v.expv,
              v.st, v.ecnt);
    end

    // Reset in the middle of a triangle discards the 6 accumulated hits.
    drive(0, 0, 0, 4'b1111, 0);
    drive(0, 0, 0, 4'b0011, 0);
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    chk_all("midrst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 4'b0000, 0);
    chk("midrst push lvl", int'(fifo_lvl), 1);
    drive(0, 0, 0, 4'b0000, 1);
    chk_all("midrst eot", 1, 0, 1, 0, 0, 0, 0, 0, 0);

    do_reset();
    for (int n = 0; n < 600; n++) begin
      c   = ($urandom_range(0, 59) == 0);
      ev  = ($urandom_range(0, 1) == 1);
      ec  = $urandom_range(0, 7);
      hv  = 4'($urandom_range(0, 15));
      eot = ($urandom_range(0, 2) == 0);
      drive(c, ev, ec, hv, eot);
      model_step(c, ev, ec, hv, eot);
      chk_all($sformatf("rnd%0d", n), (mq.size() < DEPTH), mq.size(), m_tri, m_ev, m_code,
              m_got, m_exp, m_st, m_ecnt);
`ifdef SMPL_CNT_MON_MAX_EN
      chk($sformatf("rnd%0d max_cnt", n), int'(max_cnt), m_max);
      chk($sformatf("rnd%0d zero_tri_cnt", n), int'(zero_tri_cnt), m_zero);
`endif
    end

`ifdef SMPL_CNT_MON_MAX_EN
    do_reset();
    drive(0, 0, 0, 4'b0011, 1);
    drive(0, 0, 0, 4'b1111, 0);
    drive(0, 0, 0, 4'b1111, 0);
    drive(0, 0, 0, 4'b0001, 1);
    drive(0, 0, 0, 4'b0000, 1);
    chk("stats max_cnt", int'(max_cnt), 9);
    chk("stats zero_tri_cnt", int'(zero_tri_cnt), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
